seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand/opcode presented.
REQ-005 SHALL have port in_ready  output  1  block accepts an operation.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port s  input  4  opcode.
REQ-009 SHALL have port out_valid  output  1  result held and valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port r  output  WIDTH  result (low half for MUL).
REQ-012 SHALL have port r_hi  output  WIDTH  MUL high half; 0 for every other opcode.
REQ-013 SHALL have ports c, v, z, err  output  1 each  carry, signed overflow, r==0, illegal opcode.

Function
REQ-014 SHALL decode opcodes: 1110 AND, 1101 OR, 1100 NOT a, 1011 XOR, 1010 ADD, 1001 SUB (a-b), 1000 PASS a, 0111 TEST (r=1 if a==0 else 0), 0110 SHL a by 1, 0101 SHR a by 1 (logical), 0100 MUL (unsigned).
REQ-015 SHALL treat any other opcode as illegal: r=0, r_hi=0, c=v=0, err=1, single-cycle latency.
REQ-016 SHALL set c=v=0 for AND, OR, NOT, XOR, PASS, TEST.
REQ-017 ADD SHALL set c=carry out of bit WIDTH-1 and v=signed two's-complement overflow.
REQ-018 SUB SHALL set c=borrow (1 iff a<b unsigned) and v=signed overflow of a-b.
REQ-019 SHL SHALL set c=a[WIDTH-1]; SHR SHALL set c=a[0]; v=0 for both.
REQ-020 MUL SHALL produce the full 2*WIDTH product in {r_hi,r}, c=1 iff r_hi!=0, v=0.
REQ-021 z SHALL equal (r==0) for every opcode; err=0 for every legal opcode.
REQ-022 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; MUL path IDLE -> MULT -> DONE.
REQ-023 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid && in_ready; a, b, s SHALL be registered at that edge.
REQ-024 Non-MUL ops SHALL assert out_valid exactly 2 cycles after the accepting edge; MUL SHALL assert it WIDTH+1 cycles after.
REQ-025 MULT SHALL perform one shift-add step per cycle using a counter from WIDTH-1 down to 0, leaving MULT after the step at count 0.
REQ-026 In DONE, r, r_hi, c, v, z, err SHALL hold stable while out_valid=1 && out_ready=0.
REQ-027 DONE SHALL exit to IDLE on the edge where out_ready=1; in_valid in that cycle SHALL be ignored (in_ready=0).
REQ-028 Input changes while not in IDLE SHALL have no effect on the operation in flight.

Reset
REQ-029 On rst_n=0 the FSM SHALL go to IDLE immediately (asynchronously), aborting any operation incl. mid-MUL; in_ready=1, out_valid=0, r=r_hi=0, c=v=err=0, z=1.
REQ-030 The first operation after reset release SHALL behave identically to one from a cold start.

Configuration
REQ-031 Macro SEQ_ALU_MUL_EN SHALL, when defined, compile in the MULT state and multiplier; when undefined, 0100 SHALL be treated as illegal per REQ-015 and no multiplier logic SHALL exist.

Structure
REQ-032 Package seq_alu_pkg SHALL hold the opcode enum (alu_op_e, 4-bit) and the FSM state enum; seq_alu SHALL import it.
REQ-033 The iterative multiplier SHALL be a sub-module alu_mul_unit (start, done, WIDTH param), instantiated only under SEQ_ALU_MUL_EN.

Verification (WIDTH=8)
REQ-034 ADD a=0x7F b=0x01 -> r=0x80 c=0 v=1 z=0; ADD a=0xFF b=0x01 -> r=0x00 c=1 v=0 z=1.
REQ-035 SUB a=0x05 b=0x07 -> r=0xFE c=1 v=0; SUB a=0x81 b=0x81 -> r=0x00 c=0 v=0 z=1.
REQ-036 MUL a=0xFF b=0xFF (macro defined) -> out_valid at cycle 9 after accept, r_hi=0xFE r=0x01 c=1; macro undefined -> r=0 err=1 at cycle 2.
REQ-037 SHL a=0x81 -> r=0x02 c=1; opcode 0000 -> err=1 r=0 z=1.
REQ-038 Hold out_ready=0 for 5 cycles with a new in_valid pulse -> outputs stable, in_ready=0, second op not accepted.
REQ-039 Assert rst_n=0 at MUL step 3 -> outputs reach reset values without a clock edge; next ADD 1+1 -> r=0x02.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg -- shared types for the sequential ALU.
//   alu_op_e : 4-bit opcode encoding presented on the s input
//   state_e  : control FSM states (MULT is only reachable when
//              SEQ_ALU_MUL_EN is defined)
package seq_alu_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 4'b1110,
      OP_OR   = 4'b1101,
      OP_NOT  = 4'b1100,
      OP_XOR  = 4'b1011,
      OP_ADD  = 4'b1010,
      OP_SUB  = 4'b1001,
      OP_PASS = 4'b1000,
      OP_TEST = 4'b0111,
      OP_SHL  = 4'b0110,
      OP_SHR  = 4'b0101,
      OP_MUL  = 4'b0100
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MULT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if -- request/response bundle of the sequential ALU.
//   Request : in_valid, in_ready, a, b, s (opcode)
//   Response: out_valid, out_ready, r, r_hi, c, v, z, err
//   master modport = producer/consumer side, slave modport = the ALU.
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       s;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] r_hi;
   logic             c;
   logic             v;
   logic             z;
   logic             err;

   modport master (
      output in_valid, a, b, s, out_ready,
      input  in_ready, out_valid, r, r_hi, c, v, z, err
   );

   modport slave (
      input  in_valid, a, b, s, out_ready,
      output in_ready, out_valid, r, r_hi, c, v, z, err
   );
endinterface

// File: rtl/alu_mul_unit.sv
// alu_mul_unit -- iterative unsigned shift-add multiplier, one step per
// cycle. Only instantiated when SEQ_ALU_MUL_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset (aborts a product)
//   start      : load a/b and begin WIDTH steps (counter WIDTH-1 .. 0)
//   a, b       : operands, sampled on the start edge
//   done       : high during the cycle whose closing edge does the last step
//   prod       : product as it will be after this cycle's step; valid when done
module alu_mul_unit #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic             busy;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] p;
   logic [WIDTH:0]   add;

   // p holds {partial sum, remaining multiplier bits}; each step conditionally
   // adds the multiplicand to the upper half and shifts everything right.
   always_comb begin
      add = {1'b0, p[2*WIDTH-1:WIDTH]};
      if (p[0]) add = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
   end

   assign prod = {add, p[WIDTH-1:1]};
   assign done = busy && (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         cnt   <= '0;
         mcand <= '0;
         p     <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         cnt   <= CW'(WIDTH - 1);
         mcand <= a;
         p     <= {{WIDTH{1'b0}}, b};
      end else if (busy) begin
         p   <= prod;
         cnt <= cnt - 1'b1;
         if (cnt == '0) busy <= 1'b0;
      end
   end
endmodule

// File: rtl/seq_alu.sv
// seq_alu -- sequential ALU with valid/ready handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_alu_if.slave (a, b, s in; r, r_hi, c, v, z, err out)
// Non-MUL ops: IDLE -> EXEC -> DONE. MUL (only with SEQ_ALU_MUL_EN defined):
// IDLE -> MULT (WIDTH steps) -> DONE. Without the macro, opcode 0100 is
// illegal and no multiplier exists. Results are registered and held in DONE
// until out_ready.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic      clk,
   input logic      rst_n,
   seq_alu_if.slave bus
);
   state_e           state;
   alu_op_e          op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] res;
   logic [WIDTH:0]   ext;
   logic             res_c, res_v, res_err;
   logic             accept;

   assign accept = (state == ST_IDLE) && bus.in_valid;

`ifdef SEQ_ALU_MUL_EN
   logic               mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   // Multiplier loads straight from the bus on the accept edge so the first
   // step happens on the following edge.
   assign mul_start = accept && (bus.s == OP_MUL);

   alu_mul_unit #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .a     (bus.a),
      .b     (bus.b),
      .done  (mul_done),
      .prod  (mul_prod)
   );
`endif

   always_comb begin
      res     = '0;
      ext     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_err = 1'b0;
      case (op_q)
         OP_AND:  res = a_q & b_q;
         OP_OR:   res = a_q | b_q;
         OP_NOT:  res = ~a_q;
         OP_XOR:  res = a_q ^ b_q;
         OP_PASS: res = a_q;
         OP_TEST: res = {{(WIDTH-1){1'b0}}, (a_q == '0)};
         OP_ADD: begin
            ext   = {1'b0, a_q} + {1'b0, b_q};
            res   = ext[WIDTH-1:0];
            res_c = ext[WIDTH];
            res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ext[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            // Extended subtraction: top bit is the borrow.
            ext   = {1'b0, a_q} - {1'b0, b_q};
            res   = ext[WIDTH-1:0];
            res_c = ext[WIDTH];
            res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ext[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SHL: begin
            res   = {a_q[WIDTH-2:0], 1'b0};
            res_c = a_q[WIDTH-1];
         end
         OP_SHR: begin
            res   = {1'b0, a_q[WIDTH-1:1]};
            res_c = a_q[0];
         end
         default: res_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         op_q          <= alu_op_e'('0);
         a_q           <= '0;
         b_q           <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.r         <= '0;
         bus.r_hi      <= '0;
         bus.c         <= 1'b0;
         bus.v         <= 1'b0;
         bus.z         <= 1'b1;
         bus.err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q          <= bus.a;
                  b_q          <= bus.b;
                  op_q         <= alu_op_e'(bus.s);
                  bus.in_ready <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
                  state        <= (bus.s == OP_MUL) ? ST_MULT : ST_EXEC;
`else
                  state        <= ST_EXEC;
`endif
               end
            end
            ST_EXEC: begin
               bus.r         <= res;
               bus.r_hi      <= '0;
               bus.c         <= res_c;
               bus.v         <= res_v;
               bus.z         <= (res == '0);
               bus.err       <= res_err;
               bus.out_valid <= 1'b1;
               state         <= ST_DONE;
            end
`ifdef SEQ_ALU_MUL_EN
            ST_MULT: begin
               if (mul_done) begin
                  bus.r         <= mul_prod[WIDTH-1:0];
                  bus.r_hi      <= mul_prod[2*WIDTH-1:WIDTH];
                  bus.c         <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                  bus.v         <= 1'b0;
                  bus.z         <= (mul_prod[WIDTH-1:0] == '0);
                  bus.err       <= 1'b0;
                  bus.out_valid <= 1'b1;
                  state         <= ST_DONE;
               end
            end
`endif
            ST_DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
module tb_seq_alu;
   localparam int W = 8;
`ifdef SEQ_ALU_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   seq_alu_if #(.WIDTH(W)) bus ();
   seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  s;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [19:0] exp;   // {r_hi, r, c, v, z, err}
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
      end
   endtask

   function automatic logic [19:0] pack_out();
      return {bus.r_hi, bus.r, bus.c, bus.v, bus.z, bus.err};
   endfunction

   function automatic vec_t mk(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] hi, input logic [7:0] r, input logic c,
                               input logic v, input logic z, input logic err, input int lat);
      vec_t t;
      t.s = s; t.a = a; t.b = b; t.exp = {hi, r, c, v, z, err}; t.lat = lat;
      return t;
   endfunction

   // Reference model: plain integer arithmetic on the opcode rules.
   function automatic logic [19:0] model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
      int   ia, ib, sa, sb, res, hi;
      logic cf, vf, ef;
      ia = int'(a); ib = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      res = 0; hi = 0; cf = 1'b0; vf = 1'b0; ef = 1'b0;
      case (s)
         4'b1110: res = ia & ib;
         4'b1101: res = ia | ib;
         4'b1100: res = 255 - ia;
         4'b1011: res = ia ^ ib;
         4'b1010: begin
            res = ia + ib;
            cf  = (res > 255);
            vf  = (sa + sb > 127) || (sa + sb < -128);
            res = res % 256;
         end
         4'b1001: begin
            cf  = (ia < ib);
            vf  = (sa - sb > 127) || (sa - sb < -128);
            res = (ia - ib + 256) % 256;
         end
         4'b1000: res = ia;
         4'b0111: res = (ia == 0) ? 1 : 0;
         4'b0110: begin res = (ia * 2) % 256; cf = (ia >= 128); end
         4'b0101: begin res = ia / 2; cf = (ia % 2 == 1); end
`ifdef SEQ_ALU_MUL_EN
         4'b0100: begin
            res = ia * ib;
            hi  = res / 256;
            res = res % 256;
            cf  = (hi != 0);
         end
`endif
         default: ef = 1'b1;
      endcase
      return {8'(hi), 8'(res), cf, vf, (res == 0), ef};
   endfunction

   // Issue one op, scramble the inputs while it is in flight, wait (bounded)
   // for out_valid and return the outputs and the latency in cycles.
   task automatic do_op(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                        output logic [19:0] got, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      bus.in_valid = 1'b1; bus.s = s; bus.a = a; bus.b = b;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.s = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
         bus.a = 8'($urandom); bus.b = 8'($urandom);
      end
      got = pack_out();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      vec_t        vecs[$];
      logic [19:0] got, snap, exp;
      logic [3:0]  rs;
      logic [7:0]  ra, rb;
      int          lat, guard;

      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.s = '0;

      #12;
      check("reset_state", 32'({bus.in_ready, bus.out_valid, pack_out()}),
            32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
      @(negedge clk);
      rst_n = 1'b1;

      //             s        a      b      hi     r      c     v     z     err   lat
      vecs.push_back(mk(4'b1010, 8'h7F, 8'h01, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b1010, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2));
      vecs.push_back(mk(4'b1001, 8'h05, 8'h07, 8'h00, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b1001, 8'h81, 8'h81, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2));
      vecs.push_back(mk(4'b1001, 8'h80, 8'h01, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b0110, 8'h81, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b0101, 8'h81, 8'h00, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b0000, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2));
      vecs.push_back(mk(4'b1111, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2));
      vecs.push_back(mk(4'b1110, 8'hF0, 8'h3C, 8'h00, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b1101, 8'hF0, 8'h0F, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b1100, 8'h5A, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b1011, 8'hFF, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b1000, 8'h00, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2));
      vecs.push_back(mk(4'b0111, 8'h00, 8'h55, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 2));
      vecs.push_back(mk(4'b0111, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2));
`ifdef SEQ_ALU_MUL_EN
      vecs.push_back(mk(4'b0100, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 9));
      vecs.push_back(mk(4'b0100, 8'h10, 8'h10, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 9));
      vecs.push_back(mk(4'b0100, 8'h0F, 8'h03, 8'h00, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0, 9));
`else
      vecs.push_back(mk(4'b0100, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2));
`endif

      foreach (vecs[i]) begin
         do_op(vecs[i].s, vecs[i].a, vecs[i].b, got, lat);
         check($sformatf("vec%0d_s%b_out", i, vecs[i].s), 32'(got), 32'(vecs[i].exp));
         check($sformatf("vec%0d_s%b_lat", i, vecs[i].s), 32'(lat), 32'(vecs[i].lat));
      end

      for (int i = 0; i < 150; i++) begin
         rs = 4'($urandom_range(0, 15));
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i % 10 == 0) ra = 8'h00;
         do_op(rs, ra, rb, got, lat);
         check($sformatf("rand%0d_s%b_a%h_b%h", i, rs, ra, rb), 32'(got), 32'(model(rs, ra, rb)));
         check($sformatf("rand%0d_lat", i), 32'(lat), 32'((rs == 4'b0100 && MUL_ON) ? 9 : 2));
      end

      // Back-pressure: result held while out_ready=0, new request ignored.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.s = 4'b1010; bus.a = 8'h7F; bus.b = 8'h01;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      guard = 0;
      while (!bus.out_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      snap = pack_out();
      exp = {8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
      check("hold_first_result", 32'({bus.out_valid, snap}), 32'({1'b1, exp}));
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = (k == 2);
         bus.s = 4'b1110; bus.a = 8'($urandom); bus.b = 8'($urandom);
         @(negedge clk);
         check($sformatf("hold_cycle%0d", k), 32'({bus.out_valid, bus.in_ready, pack_out()}),
               32'({1'b1, 1'b0, exp}));
      end
      // Exit cycle: in_valid high alongside out_ready must not be taken.
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.s = 4'b1101;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      check("exit_to_idle", 32'({bus.in_ready, bus.out_valid}), 32'({1'b1, 1'b0}));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("no_second_op%0d", k), 32'({bus.in_ready, bus.out_valid}), 32'({1'b1, 1'b0}));
      end

      // Asynchronous reset three cycles into an operation.
      @(negedge clk);
      bus.in_valid = 1'b1;
      if (MUL_ON) begin bus.s = 4'b0100; bus.a = 8'hFF; bus.b = 8'hFF; end
      else        begin bus.s = 4'b1010; bus.a = 8'h7F; bus.b = 8'h01; end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #2;
      check("async_reset", 32'({bus.in_ready, bus.out_valid, pack_out()}),
            32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
      @(negedge clk);
      rst_n = 1'b1;
      do_op(4'b1010, 8'h01, 8'h01, got, lat);
      check("post_reset_add", 32'(got), 32'({8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0}));
      check("post_reset_lat", 32'(lat), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
